serial_adder_ctrl: RTL and testbench
====================================

// Module: serial_adder_ctrl
//
// PURPOSE
// Bit-serial adder controller; drives one full_adder instance one bit per clock.
// Accepts two WIDTH-bit operands over a valid/ready handshake and feeds them LSB-first
// into the full_adder instance's i_bit1/i_bit2 inputs. Holds the carry in a flop fed back
// into i_cin, and shifts o_sum bits into a result register.
// Presents the WIDTH-bit sum and carry-out downstream over a second valid/ready handshake.
//
// PARAMETERS
// WIDTH   8   operand/result width in bits; legal range 1..64
//
// PORTS
// i_clk    input   1      clock; all state updates on rising edge
// i_rst    input   1      asynchronous, active-high reset
// i_valid  input   1      upstream operands valid
// o_ready  output  1      block can accept operands (high only in IDLE)
// i_a      input   WIDTH  operand A
// i_b      input   WIDTH  operand B
// o_valid  output  1      result valid (high only in DONE)
// i_ready  input   1      downstream accepts result
// o_sum    output  WIDTH  result; checked only while o_valid=1
// o_cout   output  1      final carry out; checked only while o_valid=1
// i_sub    input   1      present only with SERIAL_ADDER_SUB_EN (see CONFIGURATION)
//
// BEHAVIOUR
// - Reset (async, i_rst=1): state=IDLE, o_ready=1, o_valid=0, o_sum=0, o_cout=0.
// - Reset internals: carry=0, bit counter=0, operand shift regs=0.
// - No transfer is accepted while i_rst=1.
// - Reset asserted mid-RUN or mid-DONE aborts the operation; the result is discarded.
// - Counter width is $clog2(WIDTH+1).
// - State IDLE: o_ready=1.
//   - On i_valid=1 at an edge: latch i_a/i_b into shift regs, carry<=0, count<=0, go to RUN.
// - State RUN: o_ready=0, o_valid=0. Each edge:
//   - full_adder inputs: i_bit1=a_sh[0], i_bit2=b_sh[0], i_cin=carry.
//   - sum_sh <= {fa.o_sum, sum_sh[WIDTH-1:1]}; carry <= fa.o_carry.
//   - a_sh and b_sh shift right by 1; count++.
//   - When count reaches WIDTH-1 at an edge, go to DONE.
// - State DONE: o_valid=1; o_sum=sum_sh and o_cout=carry, both held stable.
//   - On i_ready=1 at an edge: go to IDLE.
//   - No new operands are accepted in the same cycle (o_ready=0).
// - Latency: operands accepted at edge E; o_valid rises after edge E+WIDTH.
// - Minimum spacing between accepts is WIDTH+2 cycles.
// - Backpressure: DONE persists indefinitely while i_ready=0; o_sum/o_cout do not change.
// - Arithmetic: {o_cout,o_sum} = i_a + i_b, modulo 2^(WIDTH+1).
//   - Wrap-around appears as o_cout=1 with o_sum = the low WIDTH bits.
// - i_a/i_b changing after acceptance has no effect (operands are latched).
// - WIDTH=1: RUN lasts exactly one cycle.
//
// CONFIGURATION
// Macro SERIAL_ADDER_SUB_EN.
// - Defined: adds port i_sub, sampled together with operands at the accept edge.
//   - i_sub=1: b bits are inverted into i_bit2 and carry initialises to 1,
//     so o_sum = i_a - i_b mod 2^WIDTH.
//   - In subtract mode o_cout=1 means no borrow (i_a >= i_b unsigned).
//   - i_sub=0: identical to the add-only build.
// - Undefined: no i_sub port; add only; carry always initialises to 0.
//
// TESTING
// 1. WIDTH=8, i_a=0x35, i_b=0x0A, i_ready=1 -> o_valid after 8 cycles;
//    o_sum=0x3F, o_cout=0; back in IDLE 1 cycle later.
// 2. i_a=0xFF, i_b=0x01 -> o_sum=0x00, o_cout=1 (wrap-around).
//    i_a=0xFF, i_b=0xFF -> o_sum=0xFE, o_cout=1.
// 3. Hold i_ready=0 for 5 cycles in DONE -> o_valid, o_sum and o_cout stay stable;
//    o_ready stays 0 and i_valid pulses are ignored.
// 4. Assert i_rst at RUN cycle 4 -> o_valid=0, o_ready=1, o_sum=0 immediately (async).
//    The next op (0x10+0x20) then yields 0x30.
// 5. SUB_EN: 0x07-0x05 -> o_sum=0x02, o_cout=1.
//    0x05-0x07 -> o_sum=0xFE, o_cout=0.
// 6. WIDTH=1: 1+1 -> o_sum=0, o_cout=1; back-to-back accepts spaced exactly 3 cycles.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full_adder cell is reused per clock, LSB-first, to build a WIDTH-bit sum.
// Optional subtract mode (port i_sub) is compiled in when SERIAL_ADDER_SUB_EN is defined.

module full_adder (
  input  logic i_bit1,
  input  logic i_bit2,
  input  logic i_cin,
  output logic o_sum,
  output logic o_carry
);
  assign o_sum   = i_bit1 ^ i_bit2 ^ i_cin;
  assign o_carry = (i_bit1 & i_bit2) | (i_cin & (i_bit1 ^ i_bit2));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
`ifdef SERIAL_ADDER_SUB_EN
  ,
  input  logic             i_sub
`endif
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // Upstream: o_ready is 1 only in IDLE. Downstream: o_valid is 1 only in DONE, and
  // o_sum/o_cout are held stable until the edge where i_ready is seen high.

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    count_q, count_d;
  logic             sub_q, sub_d;
  logic             sub_in;

  logic             fa_bit2;
  logic             fa_sum;
  logic             fa_carry;
  logic [WIDTH-1:0] sum_shifted;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_in = i_sub;
`else
  assign sub_in = 1'b0;
`endif

  // Subtraction is a + ~b + 1: invert b bit-by-bit and seed the carry with 1.
  assign fa_bit2 = b_q[0] ^ sub_q;

  full_adder u_fa (
    .i_bit1  (a_q[0]),
    .i_bit2  (fa_bit2),
    .i_cin   (carry_q),
    .o_sum   (fa_sum),
    .o_carry (fa_carry)
  );

  generate
    if (WIDTH == 1) begin : g_shift_w1
      assign sum_shifted = fa_sum;
    end else begin : g_shift_wn
      assign sum_shifted = {fa_sum, sum_q[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      count_q <= '0;
      sub_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      count_q <= count_d;
      sub_q   <= sub_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    count_d = count_q;
    sub_d   = sub_q;
    o_ready = 1'b0;
    o_valid = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        o_ready = 1'b1;
        if (i_valid) begin
          a_d     = i_a;
          b_d     = i_b;
          sub_d   = sub_in;
          carry_d = sub_in;
          count_d = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sum_d   = sum_shifted;
        carry_d = fa_carry;
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        count_d = count_q + CW'(1);
        if (count_q == CW'(WIDTH - 1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        o_valid = 1'b1;
        if (i_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign o_sum  = sum_q;
  assign o_cout = carry_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: an 8-bit instance and a 1-bit instance share clock and reset.
// Subtract-mode vectors run only when SERIAL_ADDER_SUB_EN is defined.

module tb_serial_adder_ctrl;

  logic       clk;
  logic       rst;

  logic       valid8, ready8_o, valid8_o, ready8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       sub8;

  logic       valid1, ready1_o, valid1_o, ready1, cout1;
  logic [0:0] a1, b1, sum1;
  logic       sub1;

  int checks;
  int failures;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_valid (valid8),
    .o_ready (ready8_o),
    .i_a     (a8),
    .i_b     (b8),
    .o_valid (valid8_o),
    .i_ready (ready8),
    .o_sum   (sum8),
    .o_cout  (cout8)
`ifdef SERIAL_ADDER_SUB_EN
    ,
    .i_sub   (sub8)
`endif
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_valid (valid1),
    .o_ready (ready1_o),
    .i_a     (a1),
    .i_b     (b1),
    .o_valid (valid1_o),
    .i_ready (ready1),
    .o_sum   (sum1),
    .o_cout  (cout1)
`ifdef SERIAL_ADDER_SUB_EN
    ,
    .i_sub   (sub1)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one 8-bit operation; returns the cycles from accept edge to o_valid and the result.
  // Called right after an edge with the DUT idle; operands are scrambled after acceptance.
  task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic sub,
                         output logic [7:0] s, output logic c, output int lat);
    a8 = a; b8 = b; sub8 = sub; valid8 = 1'b1;
    @(posedge clk); #1;
    valid8 = 1'b0; a8 = ~a; b8 = ~b; sub8 = ~sub;
    lat = 0;
    while (!valid8_o && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    s = sum8;
    c = cout8;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    valid8 = 1'b1; a8 = 8'h11; b8 = 8'h22;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ready8_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready8_o); end
    checks++;
    if (valid8_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid8_o); end
    checks++;
    if (sum8 !== 8'h00) begin failures++; $display("FAIL reset_sum got=%h exp=00", sum8); end
    checks++;
    if (cout8 !== 1'b0) begin failures++; $display("FAIL reset_cout got=%b exp=0", cout8); end
    checks++;
    if (ready1_o !== 1'b1 || valid1_o !== 1'b0) begin
      failures++; $display("FAIL reset_w1 got ready=%b valid=%b exp ready=1 valid=0", ready1_o, valid1_o);
    end
    valid8 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ready8_o !== 1'b1) begin failures++; $display("FAIL reset_release_idle got=%b exp=1", ready8_o); end
  endtask

  task automatic test_basic_add();
    logic [7:0] s; logic c; int lat;
    run_op8(8'h35, 8'h0A, 1'b0, s, c, lat);
    checks++;
    if (lat !== 8) begin failures++; $display("FAIL basic_latency got=%0d exp=8", lat); end
    checks++;
    if (s !== 8'h3F) begin failures++; $display("FAIL basic_sum got=%h exp=3f", s); end
    checks++;
    if (c !== 1'b0) begin failures++; $display("FAIL basic_cout got=%b exp=0", c); end
    checks++;
    if (ready8_o !== 1'b0) begin failures++; $display("FAIL basic_ready_in_done got=%b exp=0", ready8_o); end
    @(posedge clk); #1;
    checks++;
    if (valid8_o !== 1'b0 || ready8_o !== 1'b1) begin
      failures++; $display("FAIL basic_back_to_idle got valid=%b ready=%b exp valid=0 ready=1", valid8_o, ready8_o);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] va [4];
    logic [7:0] vb [4];
    logic [7:0] es [4];
    logic       ec [4];
    logic [7:0] s; logic c; int lat;
    va = '{8'hFF, 8'hFF, 8'h80, 8'hAA};
    vb = '{8'h01, 8'hFF, 8'h80, 8'h55};
    es = '{8'h00, 8'hFE, 8'h00, 8'hFF};
    ec = '{1'b1,  1'b1,  1'b1,  1'b0};
    for (int i = 0; i < 4; i++) begin
      run_op8(va[i], vb[i], 1'b0, s, c, lat);
      checks++;
      if (s !== es[i] || c !== ec[i] || lat !== 8) begin
        failures++;
        $display("FAIL wrap_%0d got sum=%h cout=%b lat=%0d exp sum=%h cout=%b lat=8", i, s, c, lat, es[i], ec[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] s; logic c; int lat;
    ready8 = 1'b0;
    run_op8(8'h12, 8'h34, 1'b0, s, c, lat);
    checks++;
    if (s !== 8'h46 || c !== 1'b0) begin
      failures++; $display("FAIL bp_result got sum=%h cout=%b exp sum=46 cout=0", s, c);
    end
    for (int i = 0; i < 5; i++) begin
      valid8 = 1'b1; a8 = 8'h77; b8 = 8'h66;
      @(posedge clk); #1;
      valid8 = 1'b0;
      checks++;
      if (valid8_o !== 1'b1 || ready8_o !== 1'b0 || sum8 !== 8'h46 || cout8 !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold_%0d got valid=%b ready=%b sum=%h cout=%b exp valid=1 ready=0 sum=46 cout=0",
                 i, valid8_o, ready8_o, sum8, cout8);
      end
    end
    ready8 = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (valid8_o !== 1'b0 || ready8_o !== 1'b1) begin
      failures++; $display("FAIL bp_release got valid=%b ready=%b exp valid=0 ready=1", valid8_o, ready8_o);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [7:0] s; logic c; int lat;
    a8 = 8'h35; b8 = 8'h0A; sub8 = 1'b0; valid8 = 1'b1;
    @(posedge clk); #1;
    valid8 = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (valid8_o !== 1'b0 || ready8_o !== 1'b1 || sum8 !== 8'h00) begin
      failures++;
      $display("FAIL midrun_reset got valid=%b ready=%b sum=%h exp valid=0 ready=1 sum=00", valid8_o, ready8_o, sum8);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_op8(8'h10, 8'h20, 1'b0, s, c, lat);
    checks++;
    if (s !== 8'h30 || c !== 1'b0 || lat !== 8) begin
      failures++; $display("FAIL midrun_next_op got sum=%h cout=%b lat=%0d exp sum=30 cout=0 lat=8", s, c, lat);
    end
    @(posedge clk); #1;
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub();
    logic [7:0] s; logic c; int lat;
    run_op8(8'h07, 8'h05, 1'b1, s, c, lat);
    checks++;
    if (s !== 8'h02 || c !== 1'b1) begin
      failures++; $display("FAIL sub_no_borrow got sum=%h cout=%b exp sum=02 cout=1", s, c);
    end
    @(posedge clk); #1;
    run_op8(8'h05, 8'h07, 1'b1, s, c, lat);
    checks++;
    if (s !== 8'hFE || c !== 1'b0) begin
      failures++; $display("FAIL sub_borrow got sum=%h cout=%b exp sum=fe cout=0", s, c);
    end
    @(posedge clk); #1;
    run_op8(8'h05, 8'h07, 1'b0, s, c, lat);
    checks++;
    if (s !== 8'h0C || c !== 1'b0) begin
      failures++; $display("FAIL sub_off_add got sum=%h cout=%b exp sum=0c cout=0", s, c);
    end
    @(posedge clk); #1;
  endtask
`endif

  task automatic test_width1_back_to_back();
    int hits [$];
    int lat;
    // single op 1+0 with latency
    a1 = 1'b1; b1 = 1'b0; valid1 = 1'b1;
    @(posedge clk); #1;
    valid1 = 1'b0;
    lat = 0;
    while (!valid1_o && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== 1 || sum1 !== 1'b1 || cout1 !== 1'b0) begin
      failures++; $display("FAIL w1_single got lat=%0d sum=%b cout=%b exp lat=1 sum=1 cout=0", lat, sum1, cout1);
    end
    @(posedge clk); #1;
    // continuous 1+1 requests
    a1 = 1'b1; b1 = 1'b1; valid1 = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (valid1_o) begin
        hits.push_back(k);
        checks++;
        if (sum1 !== 1'b0 || cout1 !== 1'b1) begin
          failures++; $display("FAIL w1_sum_%0d got sum=%b cout=%b exp sum=0 cout=1", k, sum1, cout1);
        end
      end
    end
    valid1 = 1'b0;
    checks++;
    if (hits.size() !== 4) begin
      failures++; $display("FAIL w1_result_count got=%0d exp=4", hits.size());
    end
    for (int i = 1; i < hits.size(); i++) begin
      checks++;
      if (hits[i] - hits[i-1] !== 3) begin
        failures++; $display("FAIL w1_spacing_%0d got=%0d exp=3", i, hits[i] - hits[i-1]);
      end
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1;
    valid8 = 1'b0; ready8 = 1'b1; a8 = '0; b8 = '0; sub8 = 1'b0;
    valid1 = 1'b0; ready1 = 1'b1; a1 = '0; b1 = '0; sub1 = 1'b0;
    test_reset();
    test_basic_add();
    test_wrap();
    test_backpressure();
    test_reset_mid_run();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    test_width1_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
